// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cpu_pipe_pkg                                                |
// | Brief   : Shared pipeline constants and hazard helper for the MIPS    |
// |           5-stage pipeline control blocks.                           |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package cpu_pipe_pkg;

  typedef logic [4:0] reg_addr_t;
  typedef logic [1:0] tcyc_t;

  // Tuse value meaning "this operand is not read"
  localparam tcyc_t TUSE_NONE = 2'd3;

  // Tnew encodings: cycles until the producer's result can be forwarded
  localparam tcyc_t TNEW_NOW = 2'd0;
  localparam tcyc_t TNEW_ONE = 2'd1;
  localparam tcyc_t TNEW_TWO = 2'd2;

  // $zero is hard-wired, so it never carries a dependency
  localparam reg_addr_t REG_ZERO = 5'd0;

  // Default MDU occupancy after a start
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  // A consumer must wait when it needs the operand sooner than the
  // producer can deliver it. TUSE_NONE exceeds any legal Tnew, so an
  // unread operand can never match.
  function automatic logic reg_hazard(
    input reg_addr_t src,
    input tcyc_t     tuse,
    input reg_addr_t wa,
    input tcyc_t     tnew
  );
    return (src != REG_ZERO) && (src == wa) && (tuse < tnew);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_busy_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : md_busy_timer                                               |
// | Brief   : Multiply/divide occupancy timer. Loads on an MDU start and  |
// |           counts down; busy covers the start cycle and every cycle   |
// |           the counter is nonzero.                                    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module md_busy_timer
  import cpu_pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] c_mult_load = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_CYC);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Load on start (a later start overrides an unfinished one), else count down to zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= is_div ? c_div_load : c_mult_load;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - c_cnt_one;
    end
  end

  // Busy is visible in the start cycle itself, before the counter loads
  assign busy = start | (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hazard_ctrl                                                 |
// | Brief   : Stall/flush controller for the 5-stage MIPS pipeline.       |
// |           Tuse/Tnew register hazards plus MDU busy hazard; freezes F  |
// |           and D, bubbles E, and counts stall cycles.                 |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_is_md,
  input  logic [4:0]  e_wa,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_div,
  output logic        f_we,
  output logic        d_we,
  output logic        e_clr,
  output logic        md_busy,
  output logic        stall,
  output logic [31:0] stall_cnt
);

  logic        w_stall_rs;
  logic        w_stall_rt;
  logic        w_stall_md;
  logic        w_stall;
  logic [31:0] r_stall_cnt;

  // The E instruction is never the one held back, so the timer loads even in a stall cycle
  md_busy_timer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_busy_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (e_md_start),
    .is_div (e_md_div),
    .busy   (md_busy)
  );

  // Hazard detection against both in-flight producers, per source operand
  always_comb begin
    w_stall_rs = reg_hazard(d_rs, d_tuse_rs, e_wa, e_tnew)
               | reg_hazard(d_rs, d_tuse_rs, m_wa, m_tnew);
    w_stall_rt = reg_hazard(d_rt, d_tuse_rt, e_wa, e_tnew)
               | reg_hazard(d_rt, d_tuse_rt, m_wa, m_tnew);
    w_stall_md = d_is_md & md_busy;
    w_stall    = w_stall_rs | w_stall_rt | w_stall_md;
  end

  // Stall cycle counter; wraps naturally at 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  // Freeze F/D and inject a bubble into E in the same cycle as the hazard
  assign stall     = w_stall;
  assign f_we      = ~w_stall;
  assign d_we      = ~w_stall;
  assign e_clr     = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
